div_seq_ctrl: RTL and testbench

DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

---
 rtl/div_pkg.sv | 7 +
 rtl/div_seq_ctrl_if.sv | 25 ++
 rtl/div_seq_ctrl.sv | 89 ++++++++
 tb/tb_div_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider controller.
package div_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  localparam int          DEFAULT_SETTLE_CYCLES = 4;
  localparam logic [31:0] DBZ_QUOTIENT          = 32'hFFFFFFFF;
endpackage

// File: rtl/div_seq_ctrl_if.sv
// Bundle between the divider controller and its parent; the parent owns the
// request inputs and routes op_a/op_b to the divider, div_result back in.
interface div_seq_ctrl_if;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [63:0] div_result;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        div_by_zero;

  modport master (
    output start, dividend, divisor, div_result,
    input  op_a, op_b, busy, done, hi_out, lo_out, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor, div_result,
    output op_a, op_b, busy, done, hi_out, lo_out, div_by_zero
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Holds operands steady on a combinational divider for SETTLE_CYCLES, then
// captures remainder/quotient into HI/LO; divide-by-zero bypasses the divider.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic           clk,
  input  logic           rst_n,
  div_seq_ctrl_if.slave  bus
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        dbz_q;
  logic        busy_q;
  logic        done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      op_a_q <= 32'd0;
      op_b_q <= 32'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      dbz_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start && (bus.divisor != 32'd0)) begin
            op_a_q <= bus.dividend;
            op_b_q <= bus.divisor;
            cnt    <= CNT_LOAD;
            dbz_q  <= 1'b0;
            state  <= SETTLE;
            busy_q <= 1'b1;
            done_q <= 1'b0;
          end else if (bus.start) begin
            // Zero divisor never touches the divider; operands keep their old values.
            hi_q   <= bus.dividend;
            lo_q   <= DBZ_QUOTIENT;
            dbz_q  <= 1'b1;
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end
        end
        SETTLE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            hi_q   <= bus.div_result[63:32];
            lo_q   <= bus.div_result[31:0];
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op_a        = op_a_q;
  assign bus.op_b        = op_b_q;
  assign bus.hi_out      = hi_q;
  assign bus.lo_out      = lo_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl with a behavioural divider; results checked from a scoreboard.
module tb_div_seq_ctrl;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_seq_ctrl_if bus ();

  div_seq_ctrl #(.SETTLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Divider: truncating signed quotient, remainder as magnitude |a| mod |b|.
  logic signed [31:0] dv_a, dv_b;
  logic        [31:0] dv_ma, dv_mb;
  always_comb begin
    dv_a  = bus.op_a;
    dv_b  = bus.op_b;
    dv_ma = dv_a[31] ? -dv_a : dv_a;
    dv_mb = dv_b[31] ? -dv_b : dv_b;
    bus.div_result = 64'd0;
    if (dv_b != 0) bus.div_result = {dv_ma % dv_mb, 32'(dv_a / dv_b)};
  end

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic do_start(input logic [31:0] a, input logic [31:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b required 000", {bus.busy, bus.done, bus.div_by_zero});
    end
    checks++;
    if ({bus.op_a, bus.op_b, bus.hi_out, bus.lo_out} !== 128'd0) begin
      errors++; $display("FAIL reset_regs: got %h required 0", {bus.op_a, bus.op_b, bus.hi_out, bus.lo_out});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    exp_t e;
    sb.push_back('{32'd2, 32'd14, 1'b0, 5});
    do_start(32'd100, 32'd7);
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        errors++; $display("FAIL basic_busy_c%0d: busy=%b done=%b required busy=1 done=0", c, bus.busy, bus.done);
      end
      @(negedge clk);
    end
    e = sb.pop_front();
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL basic_done_c5: done=%b busy=%b required done=1 busy=0", bus.done, bus.busy);
    end
    checks++;
    if ({bus.hi_out, bus.lo_out, bus.div_by_zero} !== {e.hi, e.lo, e.dbz}) begin
      errors++; $display("FAIL basic_result: got %h/%h/%b required %h/%h/%b",
                         bus.hi_out, bus.lo_out, bus.div_by_zero, e.hi, e.lo, e.dbz);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.hi_out !== e.hi || bus.lo_out !== e.lo) begin
      errors++; $display("FAIL basic_pulse_hold: done=%b hi=%h lo=%h required done=0 hi=%h lo=%h",
                         bus.done, bus.hi_out, bus.lo_out, e.hi, e.lo);
    end
  endtask

  task automatic test_negative;
    exp_t e;
    int   cyc;
    sb.push_back('{32'd2, 32'hFFFFFFF2, 1'b0, 5});
    do_start(-32'sd100, 32'd7);
    wait_done(cyc);
    e = sb.pop_front();
    checks++;
    if (bus.done !== 1'b1 || cyc != e.lat) begin
      errors++; $display("FAIL neg_latency: done=%b at cycle %0d required cycle %0d", bus.done, cyc, e.lat);
    end
    checks++;
    if ({bus.hi_out, bus.lo_out, bus.div_by_zero} !== {e.hi, e.lo, e.dbz}) begin
      errors++; $display("FAIL neg_result: got %h/%h/%b required %h/%h/%b",
                         bus.hi_out, bus.lo_out, bus.div_by_zero, e.hi, e.lo, e.dbz);
    end
    @(negedge clk);
  endtask

  task automatic test_div_zero;
    exp_t e;
    int   cyc;
    sb.push_back('{32'd5, 32'hFFFFFFFF, 1'b1, 1});
    do_start(32'd5, 32'd0);
    wait_done(cyc);
    e = sb.pop_front();
    checks++;
    if (bus.done !== 1'b1 || cyc != e.lat) begin
      errors++; $display("FAIL dbz_latency: done=%b at cycle %0d required cycle %0d", bus.done, cyc, e.lat);
    end
    checks++;
    if ({bus.hi_out, bus.lo_out, bus.div_by_zero} !== {e.hi, e.lo, e.dbz}) begin
      errors++; $display("FAIL dbz_result: got %h/%h/%b required %h/%h/%b",
                         bus.hi_out, bus.lo_out, bus.div_by_zero, e.hi, e.lo, e.dbz);
    end
    checks++;
    if (bus.op_a !== 32'hFFFFFF9C || bus.op_b !== 32'd7) begin
      errors++; $display("FAIL dbz_ops_hold: got %h/%h required ffffff9c/00000007", bus.op_a, bus.op_b);
    end
    @(negedge clk);
    sb.push_back('{32'd0, 32'd3, 1'b0, 5});
    do_start(32'd9, 32'd3);
    checks++;
    if (bus.op_a !== 32'd9 || bus.op_b !== 32'd3 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL dbz_next_load: got %h/%h busy=%b required 9/3 busy=1", bus.op_a, bus.op_b, bus.busy);
    end
    wait_done(cyc);
    e = sb.pop_front();
    checks++;
    if (bus.done !== 1'b1 || cyc != e.lat ||
        {bus.hi_out, bus.lo_out, bus.div_by_zero} !== {e.hi, e.lo, e.dbz}) begin
      errors++; $display("FAIL dbz_next_result: cycle %0d got %h/%h/%b required cycle %0d %h/%h/%b",
                         cyc, bus.hi_out, bus.lo_out, bus.div_by_zero, e.lat, e.hi, e.lo, e.dbz);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   cyc;
    sb.push_back('{32'd2, 32'd14, 1'b0, 5});
    do_start(32'd100, 32'd7);
    do_start(32'd50, 32'd5);
    wait_done(cyc);
    cyc++;
    e = sb.pop_front();
    checks++;
    if (bus.done !== 1'b1 || cyc != e.lat ||
        {bus.hi_out, bus.lo_out, bus.op_a, bus.op_b} !== {e.hi, e.lo, 32'd100, 32'd7}) begin
      errors++; $display("FAIL ignore_settle: cycle %0d hi=%h lo=%h ops=%h/%h required cycle %0d hi=%h lo=%h ops=64/7",
                         cyc, bus.hi_out, bus.lo_out, bus.op_a, bus.op_b, e.lat, e.hi, e.lo);
    end
    sb.push_back('{32'd0, 32'd10, 1'b0, 5});
    do_start(32'd50, 32'd5);
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: busy=%b done=%b required busy=1 done=0", bus.busy, bus.done);
    end
    wait_done(cyc);
    e = sb.pop_front();
    checks++;
    if (bus.done !== 1'b1 || cyc != e.lat || {bus.hi_out, bus.lo_out} !== {e.hi, e.lo}) begin
      errors++; $display("FAIL b2b_result: cycle %0d hi=%h lo=%h required cycle %0d hi=%h lo=%h",
                         cyc, bus.hi_out, bus.lo_out, e.lat, e.hi, e.lo);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    exp_t e;
    int   cyc;
    int   seen = 0;
    do_start(32'd100, 32'd7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.op_a, bus.op_b, bus.hi_out, bus.lo_out} !== 131'd0) begin
      errors++; $display("FAIL abort_async: busy=%b done=%b ops=%h/%h hi=%h lo=%h required all 0",
                         bus.busy, bus.done, bus.op_a, bus.op_b, bus.hi_out, bus.lo_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL abort_no_done: %0d active cycles after release required 0", seen);
    end
    sb.push_back('{32'd0, 32'd3, 1'b0, 5});
    do_start(32'd9, 32'd3);
    wait_done(cyc);
    e = sb.pop_front();
    checks++;
    if (bus.done !== 1'b1 || cyc != e.lat || {bus.hi_out, bus.lo_out} !== {e.hi, e.lo}) begin
      errors++; $display("FAIL abort_restart: cycle %0d hi=%h lo=%h required cycle %0d hi=%h lo=%h",
                         cyc, bus.hi_out, bus.lo_out, e.lat, e.hi, e.lo);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.dividend = 32'd0;
    bus.divisor  = 32'd0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_negative();
    test_div_zero();
    test_back_to_back();
    test_reset_abort();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_empty: %0d entries left required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
